// File: rtl/cpu_fetch_ctrl.sv
// cpu_fetch_ctrl
// Instruction-fetch sequencer for the MIPS core. Owns the program counter,
// drives the read side of the instruction memory bus (holding read/address
// across waitrequest stalls), presents each fetched word to decode over a
// valid/ready handshake, and applies taken branches after the delay slot.
// A branch to HALT_ADDR stops the core once its delay slot is consumed.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   address      instruction bus address (always equals pc_o)
//   read         instruction bus read request
//   waitrequest  bus stall; transfer completes on an edge with read=1, waitrequest=0
//   readdata     instruction word, valid on the completing edge
//   instr_o      fetched instruction presented to decode
//   instr_valid  instr_o holds an unconsumed instruction
//   instr_ready  decode accepts; consume = instr_valid & instr_ready on an edge
//   b_cond_met   consumed instruction is a taken branch/jump
//   b_target     branch destination, sampled with b_cond_met
//   pc_o         address of the instruction being fetched or held
//   active       core running; 0 once halted
module cpu_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] instr_o,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        b_cond_met,
  input  logic [31:0] b_target,
  output logic [31:0] pc_o,
  output logic        active
);

  typedef enum logic [1:0] {
    ST_START,
    ST_FETCH,
    ST_HOLD,
    ST_HALTED
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_tgt;
  logic        r_pending;
  logic        r_read;
  logic        r_instr_valid;
  logic        r_active;

  logic        w_consume;
  logic [31:0] w_pc_inc;

  assign w_consume = (r_state == ST_HOLD) && r_instr_valid && instr_ready;
  // Natural 32-bit wrap: FFFFFFFC + 4 lands on 0 as an ordinary fetch.
  assign w_pc_inc  = r_pc + 32'd4;

  // Outputs are registered alongside the state so the async reset clears
  // read/instr_valid immediately without any combinational decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_START;
      r_pc          <= RESET_VECTOR;
      r_instr       <= '0;
      r_tgt         <= '0;
      r_pending     <= 1'b0;
      r_read        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_active      <= 1'b1;
    end else begin
      case (r_state)
        ST_START: begin
          r_state <= ST_FETCH;
          r_read  <= 1'b1;
        end

        ST_FETCH: begin
          if (!waitrequest) begin
            r_instr       <= readdata;
            r_read        <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (w_consume) begin
            r_instr_valid <= 1'b0;
            if (r_pending) begin
              // Delay slot just consumed: redirect to the saved target.
              // Any branch flag on this edge is deliberately ignored.
              r_pc      <= r_tgt;
              r_pending <= 1'b0;
              if (r_tgt == HALT_ADDR) begin
                r_state  <= ST_HALTED;
                r_read   <= 1'b0;
                r_active <= 1'b0;
              end else begin
                r_state <= ST_FETCH;
                r_read  <= 1'b1;
              end
            end else begin
              if (b_cond_met) begin
                r_tgt     <= b_target;
                r_pending <= 1'b1;
              end
              r_pc    <= w_pc_inc;
              r_state <= ST_FETCH;
              r_read  <= 1'b1;
            end
          end
        end

        ST_HALTED: begin
          r_read        <= 1'b0;
          r_instr_valid <= 1'b0;
          r_active      <= 1'b0;
          r_pc          <= HALT_ADDR;
        end

        default: begin
          r_state <= ST_START;
        end
      endcase
    end
  end

  assign address     = r_pc;
  assign pc_o        = r_pc;
  assign read        = r_read;
  assign instr_o     = r_instr;
  assign instr_valid = r_instr_valid;
  assign active      = r_active;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
module tb_cpu_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] instr_o;
  logic        instr_valid;
  logic        instr_ready;
  logic        b_cond_met;
  logic [31:0] b_target;
  logic [31:0] pc_o;
  logic        active;

  int unsigned n_checks;
  int unsigned n_errors;

  cpu_fetch_ctrl #(
    .RESET_VECTOR (32'hBFC00000),
    .HALT_ADDR    (32'h00000000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .instr_o     (instr_o),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .b_cond_met  (b_cond_met),
    .b_target    (b_target),
    .pc_o        (pc_o),
    .active      (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH at pc through HOLD and its consume edge.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] data,
                           input logic bc, input logic [31:0] bt,
                           input logic [31:0] nxt);
    check("fetch_read", {31'd0, read}, 32'd1);
    check("fetch_addr", address, pc);
    check("fetch_valid", {31'd0, instr_valid}, 32'd0);
    readdata = data;
    step();
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_read", {31'd0, read}, 32'd0);
    check("hold_instr", instr_o, data);
    check("hold_pc", pc_o, pc);
    b_cond_met = bc;
    b_target   = bt;
    step();
    b_cond_met = 1'b0;
    b_target   = '0;
    check("next_valid", {31'd0, instr_valid}, 32'd0);
    check("next_read", {31'd0, read}, 32'd1);
    check("next_addr", address, nxt);
    check("next_active", {31'd0, active}, 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    waitrequest = 1'b0;
    instr_ready = 1'b1;
    readdata    = '0;
    b_cond_met  = 1'b0;
    b_target    = '0;

    // Reset state, held across the first clock edge.
    #6;
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc_o, 32'hBFC00000);
    check("rst_addr", address, 32'hBFC00000);
    check("rst_instr", instr_o, 32'h0);
    check("rst_active", {31'd0, active}, 32'd1);
    #2 reset = 1'b1;

    // Edge 0: START -> FETCH.
    step();
    // Test 1: back-to-back fetches, 2 cycles each.
    run_instr(32'hBFC00000, 32'h11110000, 1'b0, '0, 32'hBFC00004);

    // Test 2: three stall cycles at BFC00004.
    waitrequest = 1'b1;
    readdata    = 32'hEEEEEEEE;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_read", {31'd0, read}, 32'd1);
      check("stall_addr", address, 32'hBFC00004);
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    waitrequest = 1'b0;
    readdata    = 32'h22220000;
    instr_ready = 1'b0;
    step();
    check("stall_done_valid", {31'd0, instr_valid}, 32'd1);
    check("stall_done_instr", instr_o, 32'h22220000);

    // Test 3: decode back-pressure for 5 cycles; branch inputs must be inert.
    readdata   = 32'h33333333;
    b_cond_met = 1'b1;
    b_target   = 32'hDEAD0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_read", {31'd0, read}, 32'd0);
      check("bp_instr", instr_o, 32'h22220000);
      check("bp_pc", pc_o, 32'hBFC00004);
    end
    instr_ready = 1'b1;
    b_cond_met  = 1'b0;
    b_target    = '0;
    step();
    check("bp_next_read", {31'd0, read}, 32'd1);
    check("bp_next_addr", address, 32'hBFC00008);

    // Test 4: taken branch with delay slot; branch in the slot is ignored.
    run_instr(32'hBFC00008, 32'h30000008, 1'b0, '0, 32'hBFC0000C);
    run_instr(32'hBFC0000C, 32'h3000000C, 1'b0, '0, 32'hBFC00010);
    run_instr(32'hBFC00010, 32'h10000010, 1'b1, 32'hAAA00000, 32'hBFC00014);
    run_instr(32'hBFC00014, 32'h30000014, 1'b1, 32'h55550000, 32'hAAA00000);
    run_instr(32'hAAA00000, 32'h40000000, 1'b0, '0, 32'hAAA00004);
    // Branch to the halt address; its pending state must die with reset.
    run_instr(32'hAAA00004, 32'h10000004, 1'b1, 32'h00000000, 32'hAAA00008);

    // Test 6: asynchronous reset mid-stall at AAA00008.
    waitrequest = 1'b1;
    step();
    check("midstall_read", {31'd0, read}, 32'd1);
    reset = 1'b0;
    #2;
    check("async_read", {31'd0, read}, 32'd0);
    check("async_valid", {31'd0, instr_valid}, 32'd0);
    check("async_pc", pc_o, 32'hBFC00000);
    check("async_active", {31'd0, active}, 32'd1);
    waitrequest = 1'b0;
    #2 reset = 1'b1;
    step();
    // A surviving pending branch to 0 would halt on the next consume.
    run_instr(32'hBFC00000, 32'h50000000, 1'b1, 32'hFFFFFFF8, 32'hBFC00004);
    run_instr(32'hBFC00004, 32'h50000004, 1'b0, '0, 32'hFFFFFFF8);
    // PC wrap through 0 is an ordinary fetch, not a halt.
    run_instr(32'hFFFFFFF8, 32'h600000F8, 1'b0, '0, 32'hFFFFFFFC);
    run_instr(32'hFFFFFFFC, 32'h600000FC, 1'b0, '0, 32'h00000000);
    run_instr(32'h00000000, 32'h70000000, 1'b0, '0, 32'h00000004);

    // Test 5: branch to 0, delay slot consumed, then halt.
    run_instr(32'h00000004, 32'h10000000, 1'b1, 32'h00000000, 32'h00000008);
    readdata = 32'h80000008;
    step();
    check("slot_valid", {31'd0, instr_valid}, 32'd1);
    check("slot_instr", instr_o, 32'h80000008);
    step();
    check("halt_active", {31'd0, active}, 32'd0);
    check("halt_read", {31'd0, read}, 32'd0);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_pc", pc_o, 32'h00000000);
    for (int i = 0; i < 10; i++) begin
      instr_ready = i[0];
      b_cond_met  = 1'b1;
      b_target    = 32'h12345678;
      step();
      check("halted_read", {31'd0, read}, 32'd0);
      check("halted_active", {31'd0, active}, 32'd0);
      check("halted_valid", {31'd0, instr_valid}, 32'd0);
      check("halted_addr", address, 32'h00000000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
